// File: rtl/regfile_mp.sv
// Purpose : multi-port register file with two write ports, two combinational read ports
//           and a sequential clear sweep (one register zeroed per cycle).
// Latency : reads are zero-latency (combinational from raddr, optional same-cycle write
//           forwarding); writes land at the rising edge; sweep takes DEPTH cycles.
// Backpressure : no stall path; writes presented while busy=1 are discarded and flagged
//           on wr_drop in the following cycle.
//
// Ports:
//   clk              single clock, all state changes on the rising edge
//   areset           synchronous active-high reset (zeroes registers, aborts sweep)
//   we0/we1          write enables, ports 0 and 1 (port 1 wins on address collision)
//   waddr0/waddr1    write addresses
//   wdata0/wdata1    write data
//   raddr1/raddr2    read addresses
//   rout1/rout2      read data, combinational
//   clr              request a clear sweep (ignored while a sweep is running)
//   busy             high while the clear sweep runs
//   wr_drop          registered one-cycle flag: a write was discarded last cycle

module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rout1,
  output logic [DATA_W-1:0] rout2,
  input  logic              clr,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_wr_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------------
  logic w_busy;
  logic w_zaddr0;
  logic w_zaddr1;
  logic w_acc0;
  logic w_acc1;
  logic w_drop_nxt;
  logic w_sweep_last;

  assign w_busy = (r_state == ST_SWEEP);

  // A write aimed at the hardwired-zero register is simply a no-op: it is
  // neither stored nor counted as a dropped write.
  assign w_zaddr0 = ZERO_REG && (waddr0 == '0);
  assign w_zaddr1 = ZERO_REG && (waddr1 == '0);

  // "Accepted" also excludes reset so the forwarding path never shows data
  // that the reset edge is about to discard.
  assign w_acc0 = we0 && !w_busy && !areset && !w_zaddr0;
  assign w_acc1 = we1 && !w_busy && !areset && !w_zaddr1;

  assign w_drop_nxt   = w_busy && ((we0 && !w_zaddr0) || (we1 && !w_zaddr1));
  assign w_sweep_last = (r_cnt == ADDR_W'(DEPTH - 1));

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        // clr is deliberately not looked at here: no restart, no extension.
        // The counter wraps to 0 on the last step, leaving it ready for next time.
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_sweep_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_drop <= w_drop_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_acc0) begin
        r_mem[waddr0] <= wdata0;
      end
      // Issued after port 0 so port 1 wins when both hit the same address.
      if (w_acc1) begin
        r_mem[waddr1] <= wdata1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // Priority: hardwired zero, then port 1 forward, then port 0 forward, then
  // stored value. Sweep writes never forward because w_acc* is low while busy.
  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              acc0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              acc1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (ZERO_REG && (a == '0)) begin
      v = '0;
    end else if (BYPASS && acc1 && (wa1 == a)) begin
      v = wd1;
    end else if (BYPASS && acc0 && (wa0 == a)) begin
      v = wd0;
    end
    return v;
  endfunction

  assign rout1 = f_read(raddr1, r_mem[raddr1], w_acc0, waddr0, wdata0,
                        w_acc1, waddr1, wdata1);
  assign rout2 = f_read(raddr2, r_mem[raddr2], w_acc0, waddr0, wdata0,
                        w_acc1, waddr1, wdata1);

  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// Purpose : directed self-checking bench for regfile_mp (default build plus a
//           ZERO_REG=1 / BYPASS=0 build sharing clock and reset).
// Latency : inputs driven 1 ns after the rising edge, outputs sampled 2 ns after.
// Backpressure : n/a.

module tb_regfile_mp;

  logic       clk;
  logic       areset;

  // default instance (ZERO_REG=0, BYPASS=1)
  logic       we0, we1, clr;
  logic [2:0] waddr0, waddr1, raddr1, raddr2;
  logic [7:0] wdata0, wdata1;
  logic [7:0] rout1, rout2;
  logic       busy, wr_drop;

  // ZERO_REG=1, BYPASS=0 instance
  logic       z_we0, z_we1, z_clr;
  logic [2:0] z_waddr0, z_waddr1, z_raddr1, z_raddr2;
  logic [7:0] z_wdata0, z_wdata1;
  logic [7:0] z_rout1, z_rout2;
  logic       z_busy, z_wr_drop;

  int n_checks;
  int n_errors;

  regfile_mp dut (
    .clk    (clk),
    .areset (areset),
    .we0    (we0),
    .we1    (we1),
    .waddr0 (waddr0),
    .waddr1 (waddr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rout1  (rout1),
    .rout2  (rout2),
    .clr    (clr),
    .busy   (busy),
    .wr_drop(wr_drop)
  );

  regfile_mp #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_z (
    .clk    (clk),
    .areset (areset),
    .we0    (z_we0),
    .we1    (z_we1),
    .waddr0 (z_waddr0),
    .waddr1 (z_waddr1),
    .wdata0 (z_wdata0),
    .wdata1 (z_wdata1),
    .raddr1 (z_raddr1),
    .raddr2 (z_raddr2),
    .rout1  (z_rout1),
    .rout2  (z_rout2),
    .clr    (z_clr),
    .busy   (z_busy),
    .wr_drop(z_wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles;
    n_checks = 0;
    n_errors = 0;

    areset = 1'b1;
    we0 = 0; we1 = 0; clr = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr1 = 0; raddr2 = 0;
    z_we0 = 0; z_we1 = 0; z_clr = 0;
    z_waddr0 = 0; z_waddr1 = 0; z_wdata0 = 0; z_wdata1 = 0; z_raddr1 = 0; z_raddr2 = 0;
    step();
    step();
    areset = 1'b0;

    // ---- reset state ----
    raddr1 = 3'd3; raddr2 = 3'd7;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_reg3", rout1, 8'h00);
    chk("rst_reg7", rout2, 8'h00);
    chk("rst_z_busy", z_busy, 0);

    // ---- dual write, different addresses: 3<=AA, 5<=55 ----
    we0 = 1; waddr0 = 3'd3; wdata0 = 8'hAA;
    we1 = 1; waddr1 = 3'd5; wdata1 = 8'h55;
    raddr1 = 3'd3; raddr2 = 3'd5;
    #1;
    chk("byp_p0", rout1, 8'hAA);
    chk("byp_p1", rout2, 8'h55);
    step();
    we0 = 0; we1 = 0;
    #1;
    chk("stored_reg3", rout1, 8'hAA);
    chk("stored_reg5", rout2, 8'h55);
    chk("wr_drop_idle", wr_drop, 0);

    // ---- same-address collision: port 1 wins, also in the forward path ----
    we0 = 1; waddr0 = 3'd2; wdata0 = 8'h11;
    we1 = 1; waddr1 = 3'd2; wdata1 = 8'h22;
    raddr1 = 3'd2;
    #1;
    chk("collide_byp", rout1, 8'h22);
    step();
    we0 = 0; we1 = 0;
    #1;
    chk("collide_reg2", rout1, 8'h22);

    // ---- load every register with 0x10+k (k and k+4 per cycle) ----
    for (int k = 0; k < 4; k++) begin
      we0 = 1; waddr0 = 3'(k);     wdata0 = 8'(8'h10 + k);
      we1 = 1; waddr1 = 3'(k + 4); wdata1 = 8'(8'h14 + k);
      step();
    end
    we0 = 0; we1 = 0;
    raddr1 = 3'd0; raddr2 = 3'd7;
    #1;
    chk("load_reg0", rout1, 8'h10);
    chk("load_reg7", rout2, 8'h17);

    // ---- ZERO_REG=1 / BYPASS=0 instance ----
    z_we0 = 1; z_waddr0 = 3'd0; z_wdata0 = 8'h7F; z_raddr1 = 3'd0;
    #1;
    chk("z_reg0_before", z_rout1, 8'h00);
    step();
    z_we0 = 0;
    #1;
    chk("z_reg0_after", z_rout1, 8'h00);
    chk("z_wr_drop", z_wr_drop, 0);
    z_we0 = 1; z_waddr0 = 3'd1; z_wdata0 = 8'h33; z_raddr1 = 3'd1;
    #1;
    chk("z_nobyp_old", z_rout1, 8'h00);
    step();
    z_we0 = 0;
    #1;
    chk("z_nobyp_new", z_rout1, 8'h33);

    // ---- clear sweep with regs loaded ----
    clr = 1;
    step();
    clr = 0;
    // cycle c (1..8) ends with the edge that clears reg c-1
    for (int c = 1; c <= 8; c++) begin
      raddr1 = 3'(c - 1);
      raddr2 = (c >= 2) ? 3'(c - 2) : 3'd0;
      we0 = (c == 6);
      waddr0 = 3'd4; wdata0 = 8'hF0;
      clr = (c == 7);
      #1;
      chk($sformatf("sweep_busy_c%0d", c), busy, 1);
      chk($sformatf("sweep_pending_c%0d", c), rout1, 32'(8'h10 + c - 1));
      if (c >= 2) chk($sformatf("sweep_cleared_c%0d", c), rout2, 8'h00);
      chk($sformatf("sweep_wr_drop_c%0d", c), wr_drop, (c == 7) ? 1 : 0);
      step();
    end
    we0 = 0; clr = 0;
    #1;
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_wr_drop", wr_drop, 0);
    for (int k = 0; k < 8; k++) begin
      raddr1 = 3'(k);
      #1;
      chk($sformatf("sweep_end_reg%0d", k), rout1, 8'h00);
    end
    step();
    chk("no_restart_busy", busy, 0);

    // ---- reset mid-sweep (cnt=3) overrides write and clr ----
    we0 = 1; waddr0 = 3'd6; wdata0 = 8'h66;
    we1 = 1; waddr1 = 3'd7; wdata1 = 8'h77;
    step();
    we0 = 0; we1 = 0;
    clr = 1;
    step();
    clr = 0;
    step();
    step();
    step();
    // now in the cycle where cnt=3
    areset = 1; clr = 1; we0 = 1; waddr0 = 3'd6; wdata0 = 8'h99;
    step();
    areset = 0; clr = 0; we0 = 0;
    raddr1 = 3'd6; raddr2 = 3'd7;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr_drop", wr_drop, 0);
    chk("arst_reg6", rout1, 8'h00);
    chk("arst_reg7", rout2, 8'h00);

    // ---- clr together with a write: write lands, then gets swept ----
    we1 = 1; waddr1 = 3'd7; wdata1 = 8'h77; clr = 1;
    step();
    we1 = 0; clr = 0;
    raddr1 = 3'd7;
    #1;
    chk("clrwr_stored", rout1, 8'h77);
    busy_cycles = 0;
    for (int g = 0; g < 20 && busy; g++) begin
      busy_cycles++;
      step();
    end
    chk("fresh_sweep_len", busy_cycles, 8);
    #1;
    chk("clrwr_swept", rout1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
